v_mem_responder: RTL and testbench

V_MEM_RESPONDER -- requirements
Module: v_mem_responder

---
 rtl/v_mem_responder_pkg.sv | 18 +
 rtl/v_mem_bank.sv | 35 +++
 rtl/v_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_v_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_mem_responder_pkg.sv
// Shared vector defines for the vector memory responder.
// Holds the default geometry (vector width, beat width, depth, address width)
// and the FSM state encoding used by v_mem_responder.
package v_mem_responder_pkg;

    localparam int unsigned VMEM_VLEN       = 512;
    localparam int unsigned VMEM_BEAT_W     = 64;
    localparam int unsigned VMEM_DEPTH      = 1024;
    localparam int unsigned VMEM_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } vmem_state_t;

endpackage

// File: rtl/v_mem_bank.sv
// Single-port storage bank, DEPTH x BEAT_W words.
// Synchronous write, registered read (data for the address presented in one
// cycle appears on o_rdata in the next). Contents are not reset.
// Ports:
//   clk      clock
//   i_we     write enable for i_addr
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data
module v_mem_bank #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [BEAT_W-1:0] i_wdata,
    output logic [BEAT_W-1:0] o_rdata
);

    logic [BEAT_W-1:0] r_mem [DEPTH];
    logic [BEAT_W-1:0] r_rdata;

    // Storage array and read register; no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/v_mem_responder.sv
// Vector load/store responder: accepts one VLEN-bit request at a time and
// moves it to/from a BEAT_W-wide bank one beat per cycle, with word addresses
// wrapping modulo DEPTH. Optional macro VMEM_ALIGN_CHECK_EN rejects requests
// not aligned to VLEN/8 bytes with an error completion and no storage access.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid_i   request present            req_ready_o   accepting (IDLE)
//   req_we_i      1=store 0=load             req_addr_i    byte base address
//   req_wdata_i   store data
//   resp_valid_o  one-cycle completion pulse resp_rdata_o  load data (held)
//   resp_err_o    error completion           busy_o        request in flight
module v_mem_responder
    import v_mem_responder_pkg::*;
#(
    parameter int unsigned VLEN   = VMEM_VLEN,
    parameter int unsigned BEAT_W = VMEM_BEAT_W,
    parameter int unsigned DEPTH  = VMEM_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [VMEM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [VLEN-1:0]            req_wdata_i,
    output logic                       resp_valid_o,
    output logic [VLEN-1:0]            resp_rdata_o,
    output logic                       resp_err_o,
    output logic                       busy_o
);

    localparam int unsigned NBEATS = VLEN / BEAT_W;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned BOFF   = $clog2(BEAT_W / 8);
    localparam int unsigned CW     = $clog2(NBEATS + 1);

    vmem_state_t       r_state;
    vmem_state_t       w_state_nxt;
    logic [CW-1:0]     r_beat;
    logic [AW-1:0]     r_base;
    logic [VLEN-1:0]   r_wdata;
    logic [VLEN-1:0]   r_rdata;
    logic              r_resp_valid;
    logic              r_ready;
    logic              r_busy;
    logic              w_accept;
    logic              w_mem_we;
    logic              w_capture;
    logic [AW-1:0]     w_mem_addr;
    logic [BEAT_W-1:0] w_bank_rdata;
    logic              w_unused_addr;

    assign w_accept      = (r_state == ST_IDLE) && req_valid_i;
    assign w_mem_addr    = r_base + AW'(r_beat);
    assign w_unused_addr = ^req_addr_i;

`ifdef VMEM_ALIGN_CHECK_EN
    localparam int unsigned ALIGN_W = $clog2(VLEN / 8);
    logic w_misalign;
    logic r_resp_err;

    assign w_misalign = |req_addr_i[ALIGN_W-1:0];

    // RESP entered straight from IDLE only happens for a rejected request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_err <= 1'b0;
        end else begin
            r_resp_err <= (r_state == ST_IDLE) && (w_state_nxt == ST_RESP);
        end
    end

    assign resp_err_o = r_resp_err;
`else
    assign resp_err_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bank control. READ runs NBEATS+1 cycles because the
    // last beat comes back one cycle after its read is issued.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
`ifdef VMEM_ALIGN_CHECK_EN
                    if (w_misalign) begin
                        w_state_nxt = ST_RESP;
                    end else
`endif
                    if (req_we_i) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                w_mem_we = 1'b1;
                if (r_beat == CW'(NBEATS - 1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_READ: begin
                w_capture = (r_beat != '0);
                if (r_beat == CW'(NBEATS)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered handshake outputs. Store data shifts down one
    // beat per write; load beats shift in from the top so beat 0 ends at LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat       <= '0;
            r_base       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_resp_valid <= (w_state_nxt == ST_RESP);
            r_ready      <= (w_state_nxt == ST_IDLE);
            r_busy       <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_base  <= req_addr_i[BOFF +: AW];
                r_wdata <= req_wdata_i;
                r_beat  <= '0;
            end else if ((r_state == ST_WRITE) || (r_state == ST_READ)) begin
                r_beat <= r_beat + CW'(1);
            end
            if (w_mem_we) begin
                r_wdata <= VLEN'(r_wdata >> BEAT_W);
            end
            if (w_capture) begin
                r_rdata <= VLEN'({w_bank_rdata, r_rdata} >> BEAT_W);
            end
        end
    end

    v_mem_bank #(
        .DEPTH  (DEPTH),
        .BEAT_W (BEAT_W),
        .AW     (AW)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wdata[BEAT_W-1:0]),
        .o_rdata (w_bank_rdata)
    );

    assign req_ready_o  = r_ready;
    assign busy_o       = r_busy;
    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_rdata;

endmodule

// File: tb/tb_v_mem_responder.sv
// Self-checking bench for v_mem_responder: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a word-array model.
module tb_v_mem_responder;

    localparam int unsigned VLEN   = 512;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned NBEATS = VLEN / BEAT_W;
`ifdef VMEM_ALIGN_CHECK_EN
    localparam bit ACHK = 1'b1;
`else
    localparam bit ACHK = 1'b0;
`endif

    typedef struct {
        logic            we;
        logic [31:0]     addr;
        logic [VLEN-1:0] wdata;
        logic [VLEN-1:0] exp_rd;
        logic            exp_err;
        int              exp_lat;
    } vec_t;

    logic            clk;
    logic            rst;
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [31:0]     req_addr_i;
    logic [VLEN-1:0] req_wdata_i;
    logic            resp_valid_o;
    logic [VLEN-1:0] resp_rdata_o;
    logic            resp_err_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;

    // Reference model: plain word array plus the last completed load.
    logic [BEAT_W-1:0] m_mem [DEPTH];
    logic [VLEN-1:0]   m_last;

    v_mem_responder #(
        .VLEN   (VLEN),
        .BEAT_W (BEAT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] pat(input logic [63:0] base);
        logic [VLEN-1:0] v;
        for (int i = 0; i < int'(NBEATS); i++) v[i*BEAT_W +: BEAT_W] = base + 64'(i);
        return v;
    endfunction

    function automatic logic [VLEN-1:0] rnd_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < int'(VLEN / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [VLEN-1:0] wd,
                                input logic [VLEN-1:0] er, input logic ee, input int el);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.exp_rd = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    // Model: word index is the byte address over 8, wrapping modulo DEPTH.
    task automatic model_op(input logic we, input logic [31:0] addr, input logic [VLEN-1:0] wd,
                            output logic [VLEN-1:0] exp_rd, output logic exp_err, output int exp_lat);
        int w;
        w = int'((addr / 32'(BEAT_W / 8)) % 32'(DEPTH));
        exp_rd = m_last;
        if (ACHK && ((addr % 32'(VLEN / 8)) != 32'd0)) begin
            exp_err = 1'b1;
            exp_lat = 0;
        end else if (we) begin
            for (int i = 0; i < int'(NBEATS); i++) m_mem[(w + i) % int'(DEPTH)] = wd[i*BEAT_W +: BEAT_W];
            exp_err = 1'b0;
            exp_lat = int'(NBEATS);
        end else begin
            for (int i = 0; i < int'(NBEATS); i++) exp_rd[i*BEAT_W +: BEAT_W] = m_mem[(w + i) % int'(DEPTH)];
            m_last  = exp_rd;
            exp_err = 1'b0;
            exp_lat = int'(NBEATS) + 1;
        end
    endtask

    // Call #1 after a clock edge; returns cycles from accept edge to pulse.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [VLEN-1:0] wd,
                         output int lat, output logic [VLEN-1:0] rd, output logic err);
        int guard;
        req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_valid_i = 1'b1;
        guard = 0;
        while (!req_ready_o && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        lat = 0;
        while (!resp_valid_o && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rd  = resp_rdata_o;
        err = resp_err_o;
        @(posedge clk); #1;
    endtask

    task automatic run_checked(input string nm, input logic we, input logic [31:0] addr,
                               input logic [VLEN-1:0] wd);
        logic [VLEN-1:0] erd, rd;
        logic eerr, err;
        int elat, lat;
        model_op(we, addr, wd, erd, eerr, elat);
        issue(we, addr, wd, lat, rd, err);
        chk({nm, "_rdata"}, rd, erd);
        chk({nm, "_err"}, VLEN'(err), VLEN'(eerr));
        chk({nm, "_lat"}, VLEN'(lat), VLEN'(elat));
    endtask

    initial begin
        vec_t            tbl [8];
        logic [VLEN-1:0] p1, p2, p3, p4, mix, rd, erd, a55, aaa;
        logic            err, eerr, we;
        logic [31:0]     addr;
        int              lat, elat, n;
        bit              early, saw;
        logic [31:0]     q_addr [$];

        rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        m_last = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ready", VLEN'(req_ready_o), VLEN'(1));
        chk("rst_busy", VLEN'(busy_o), VLEN'(0));
        chk("rst_valid", VLEN'(resp_valid_o), VLEN'(0));
        chk("rst_err", VLEN'(resp_err_o), VLEN'(0));
        chk("rst_rdata", resp_rdata_o, '0);

        p1 = pat(64'h1111_0000_0000_0000);
        p2 = pat(64'h2222_0000_0000_0000);
        p3 = pat(64'h3333_0000_0000_0000);
        p4 = pat(64'h4444_0000_0000_0000);
        mix = {p3[VLEN-1:VLEN/2], p2[VLEN-1:VLEN/2]};

        tbl[0] = mk(1'b1, 32'h0000_0100, p1, '0, 1'b0, 8);
        tbl[1] = mk(1'b0, 32'h0000_0100, '0, p1, 1'b0, 9);
        tbl[2] = mk(1'b1, 32'h0000_0000, p3, p1, 1'b0, 8);
        tbl[3] = mk(1'b1, 32'h0000_1FE0, p2, p1, ACHK, ACHK ? 0 : 8);
        tbl[4] = mk(1'b0, 32'h0000_0000, '0, ACHK ? p3 : mix, 1'b0, 9);
        tbl[5] = mk(1'b0, 32'h0000_1FE0, '0, ACHK ? p3 : p2, ACHK, ACHK ? 0 : 9);
        tbl[6] = mk(1'b1, 32'h0000_1000, p4, ACHK ? p3 : p2, 1'b0, 8);
        tbl[7] = mk(1'b0, 32'h0000_1000, '0, p4, 1'b0, 9);

        for (int k = 0; k < 8; k++) begin
            model_op(tbl[k].we, tbl[k].addr, tbl[k].wdata, erd, eerr, elat);
            issue(tbl[k].we, tbl[k].addr, tbl[k].wdata, lat, rd, err);
            chk($sformatf("vec%0d_rdata", k), rd, tbl[k].exp_rd);
            chk($sformatf("vec%0d_err", k), VLEN'(err), VLEN'(tbl[k].exp_err));
            chk($sformatf("vec%0d_lat", k), VLEN'(lat), VLEN'(tbl[k].exp_lat));
        end

        // Hold req_valid_i high across a load; the next accept must wait for RESP.
        req_we_i = 1'b0; req_addr_i = 32'h0000_0100; req_wdata_i = '0; req_valid_i = 1'b1;
        @(posedge clk); #1;
        n = 0; early = 1'b0;
        while (!resp_valid_o && n < 50) begin
            if (req_ready_o) early = 1'b1;
            @(posedge clk); #1; n++;
        end
        model_op(1'b0, 32'h0000_0100, '0, erd, eerr, elat);
        chk("hold_lat1", VLEN'(n), VLEN'(9));
        chk("hold_rdata1", resp_rdata_o, erd);
        chk("hold_ready_in_pulse", VLEN'(req_ready_o), VLEN'(0));
        chk("hold_no_early_ready", VLEN'(early), VLEN'(0));
        @(posedge clk); #1;
        chk("hold_ready_after", VLEN'(req_ready_o), VLEN'(1));
        chk("hold_busy_after", VLEN'(busy_o), VLEN'(0));
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("hold_second_accept", VLEN'(busy_o), VLEN'(1));
        n = 0;
        while (!resp_valid_o && n < 50) begin
            @(posedge clk); #1; n++;
        end
        model_op(1'b0, 32'h0000_0100, '0, erd, eerr, elat);
        chk("hold_lat2", VLEN'(n), VLEN'(9));
        chk("hold_rdata2", resp_rdata_o, erd);
        @(posedge clk); #1;

        // Sub-vector-aligned store: error with the check, plain store without.
        run_checked("mis_store", 1'b1, 32'h0000_0104, pat(64'h5A5A_0000_0000_0000));
        run_checked("mis_load", 1'b0, 32'h0000_0100, '0);

        // Fill every word so random loads always hit known data.
        for (int k = 0; k < int'(DEPTH / NBEATS); k++) begin
            model_op(1'b1, 32'(k * int'(VLEN / 8)), rnd_vec(), erd, eerr, elat);
        end
        for (int k = 0; k < int'(DEPTH / NBEATS); k++) begin
            addr = 32'(k * int'(VLEN / 8));
            erd = '0;
            for (int i = 0; i < int'(NBEATS); i++) erd[i*BEAT_W +: BEAT_W] = m_mem[k * int'(NBEATS) + i];
            issue(1'b1, addr, erd, lat, rd, err);
            if (k % 32 == 0) chk($sformatf("fill%0d_lat", k), VLEN'(lat), VLEN'(NBEATS));
        end

        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            if (!we && q_addr.size() > 0 && $urandom_range(0, 1) == 1)
                addr = q_addr[$urandom_range(0, q_addr.size() - 1)];
            else if ($urandom_range(0, 1) == 1)
                addr = $urandom & 32'hFFFF_FFC0;
            else
                addr = $urandom;
            if (we) q_addr.push_back(addr);
            run_checked($sformatf("rnd%0d", k), we, addr, rnd_vec());
        end

        // Reset in the middle of a store: beats 0..2 land, the rest do not.
        a55 = {(VLEN/8){8'h55}};
        aaa = {(VLEN/8){8'hAA}};
        run_checked("pre55", 1'b1, 32'h0, a55);
        req_we_i = 1'b1; req_addr_i = 32'h0; req_wdata_i = aaa; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", VLEN'(busy_o), VLEN'(0));
        chk("abort_rdata", resp_rdata_o, '0);
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid_o) saw = 1'b1;
        end
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (resp_valid_o) saw = 1'b1;
        end
        chk("abort_no_resp", VLEN'(saw), VLEN'(0));
        chk("abort_ready", VLEN'(req_ready_o), VLEN'(1));
        for (int i = 0; i < 3; i++) m_mem[i] = aaa[BEAT_W-1:0];
        m_last = '0;
        run_checked("abort_load", 1'b0, 32'h0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
